// File: rtl/ball_sprite_gen.sv
// ball_sprite_gen
// Generates a SIZE x SIZE circular ball sprite arithmetically per pixel.
// It uses a 3-stage pipeline with one pixel per cycle and no stalls.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   frame_tick                 start-of-vblank pulse: latches ball_x/ball_y, advances blink
//   ball_x, ball_y             requested sprite top-left corner
//   pix_valid, pix_x, pix_y    scanned pixel and its qualifier
//   show, ring_mode, blink_en  sprite enable, hollow-ring select, blink enable
//   out_valid                  pix_valid delayed by 3 cycles
//   sprite_on                  sprite pixel lit, aligned with out_valid
//   in_box                     pixel inside the sprite box, aligned with out_valid
module ball_sprite_gen #(
    parameter int SIZE         = 32,
    parameter int COORD_W      = 10,
    parameter int RING         = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               show,
    input  logic               ring_mode,
    input  logic               blink_en,
    output logic               out_valid,
    output logic               sprite_on,
    output logic               in_box
);

    localparam int LOG2    = $clog2(SIZE);
    localparam int D2W     = 2 * LOG2 + 2;
    localparam int CW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int INNER_R = SIZE - 2 - 2 * RING;

    localparam logic [D2W-1:0]     OUTER_T    = D2W'((SIZE - 2) * (SIZE - 2));
    localparam logic [D2W-1:0]     INNER_T    = D2W'(INNER_R * INNER_R);
    localparam logic [LOG2:0]      SIZE_E     = (LOG2 + 1)'(SIZE);
    localparam logic [COORD_W-1:0] SIZE_C     = COORD_W'(SIZE);
    localparam logic [CW-1:0]      BLINK_LAST = CW'(BLINK_FRAMES - 1);

    // |2c+1-SIZE|: the distance from the box centre in half-pixel units.
    // This is always odd and at most SIZE-1.
    function automatic logic [LOG2:0] half_dist(input logic [LOG2-1:0] c);
        logic [LOG2:0] t;
        t = {c, 1'b1};
        half_dist = (t >= SIZE_E) ? (t - SIZE_E) : (SIZE_E - t);
    endfunction

    logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               vis_q, vis_d;

    logic               s1_valid_q, s1_valid_d, s1_box_q, s1_box_d;
    logic               s1_show_q, s1_show_d, s1_ring_q, s1_ring_d;
    logic [LOG2-1:0]    s1_u_q, s1_u_d, s1_v_q, s1_v_d;

    logic               s2_valid_q, s2_valid_d, s2_box_q, s2_box_d;
    logic               s2_show_q, s2_show_d, s2_ring_q, s2_ring_d;
    logic [D2W-1:0]     s2_d2_q, s2_d2_d;

    logic               out_valid_q, out_valid_d, sprite_on_q, sprite_on_d;
    logic               in_box_q, in_box_d;

    logic [COORD_W:0]   u_full, v_full;
    logic [D2W-1:0]     ax, ay;
    logic               outer, inner, lit;

    always_comb begin
        // The new position only takes effect after the tick cycle.
        // A pixel in the tick cycle still sees the old act_*_q.
        act_x_d = act_x_q;
        act_y_d = act_y_q;
        if (frame_tick) begin
            act_x_d = ball_x;
            act_y_d = ball_y;
        end

        cnt_d = cnt_q;
        vis_d = vis_q;
        if (!blink_en) begin
            cnt_d = '0;
            vis_d = 1'b1;
        end else if (frame_tick) begin
            if (cnt_q == BLINK_LAST) begin
                cnt_d = '0;
                vis_d = ~vis_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // S1: offsets use one extra bit so negative offsets clip instead of wrapping.
        u_full     = {1'b0, pix_x} - {1'b0, act_x_q};
        v_full     = {1'b0, pix_y} - {1'b0, act_y_q};
        s1_valid_d = pix_valid;
        s1_box_d   = !u_full[COORD_W] && (u_full[COORD_W-1:0] < SIZE_C) &&
                     !v_full[COORD_W] && (v_full[COORD_W-1:0] < SIZE_C);
        s1_u_d     = u_full[LOG2-1:0];
        s1_v_d     = v_full[LOG2-1:0];
        s1_show_d  = show;
        s1_ring_d  = ring_mode;

        // S2: squared distance, kept at full width.
        ax         = D2W'(half_dist(s1_u_q));
        ay         = D2W'(half_dist(s1_v_q));
        s2_d2_d    = ax * ax + ay * ay;
        s2_valid_d = s1_valid_q;
        s2_box_d   = s1_box_q;
        s2_show_d  = s1_show_q;
        s2_ring_d  = s1_ring_q;

        // S3
        outer       = (s2_d2_q <= OUTER_T);
        inner       = (s2_d2_q < INNER_T);
        lit         = s2_ring_q ? (outer & ~inner) : outer;
        out_valid_d = s2_valid_q;
        in_box_d    = s2_valid_q & s2_box_q;
        sprite_on_d = s2_valid_q & s2_box_q & s2_show_q & vis_q & lit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_x_q     <= '0;
            act_y_q     <= '0;
            cnt_q       <= '0;
            vis_q       <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_box_q    <= 1'b0;
            s1_show_q   <= 1'b0;
            s1_ring_q   <= 1'b0;
            s1_u_q      <= '0;
            s1_v_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_box_q    <= 1'b0;
            s2_show_q   <= 1'b0;
            s2_ring_q   <= 1'b0;
            s2_d2_q     <= '0;
            out_valid_q <= 1'b0;
            sprite_on_q <= 1'b0;
            in_box_q    <= 1'b0;
        end else begin
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            cnt_q       <= cnt_d;
            vis_q       <= vis_d;
            s1_valid_q  <= s1_valid_d;
            s1_box_q    <= s1_box_d;
            s1_show_q   <= s1_show_d;
            s1_ring_q   <= s1_ring_d;
            s1_u_q      <= s1_u_d;
            s1_v_q      <= s1_v_d;
            s2_valid_q  <= s2_valid_d;
            s2_box_q    <= s2_box_d;
            s2_show_q   <= s2_show_d;
            s2_ring_q   <= s2_ring_d;
            s2_d2_q     <= s2_d2_d;
            out_valid_q <= out_valid_d;
            sprite_on_q <= sprite_on_d;
            in_box_q    <= in_box_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sprite_on = sprite_on_q;
    assign in_box    = in_box_q;

endmodule
